// File: rtl/fetch_pkg.sv
// Shared types and counter constants for the fetch predictor.
// FETCH_BHT_EN adds a 2-bit direction counter to each BTB entry.
package fetch_pkg;
   typedef logic [31:0] pc_t;

   localparam logic [1:0] CTR_SNT = 2'd0;
   localparam logic [1:0] CTR_WNT = 2'd1;
   localparam logic [1:0] CTR_WT  = 2'd2;
   localparam logic [1:0] CTR_ST  = 2'd3;

   // tag holds pc >> (IDX+2); bits above the real tag width stay zero
   typedef struct packed {
      logic       valid;
      pc_t        tag;
      pc_t        target;
`ifdef FETCH_BHT_EN
      logic [1:0] ctr;
`endif
   } btb_entry_t;

`ifdef FETCH_BHT_EN
   function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
      if (taken) return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
      else       return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
   endfunction
`endif
endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer: async lookup, sync update, sync clear.
// FETCH_BHT_EN selects counter-based direction; otherwise a hit means taken.
module fetch_btb
   import fetch_pkg::*;
#(
   parameter int ENTRIES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] rd_pc,
   output logic        rd_taken,
   output logic [31:0] rd_target,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic [31:0] upd_target,
   input  logic        upd_taken
);
   localparam int IDX = $clog2(ENTRIES);

   btb_entry_t mem [ENTRIES];

   // Shifting out pc[1:0] first keeps index/tag extraction uniform for both ports
   pc_t            rd_sh, up_sh, rd_tag, up_tag;
   logic [IDX-1:0] rd_idx, up_idx;
   logic           rd_hit, up_hit;

   assign rd_sh  = rd_pc >> 2;
   assign up_sh  = upd_pc >> 2;
   assign rd_idx = rd_sh[IDX-1:0];
   assign up_idx = up_sh[IDX-1:0];
   assign rd_tag = rd_sh >> IDX;
   assign up_tag = up_sh >> IDX;
   assign rd_hit = mem[rd_idx].valid && (mem[rd_idx].tag == rd_tag);
   assign up_hit = mem[up_idx].valid && (mem[up_idx].tag == up_tag);

   assign rd_target = mem[rd_idx].target;
`ifdef FETCH_BHT_EN
   assign rd_taken = rd_hit && mem[rd_idx].ctr[1];
`else
   assign rd_taken = rd_hit;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            mem[i].valid <= 1'b0;
`ifdef FETCH_BHT_EN
            mem[i].ctr   <= CTR_WNT;
`endif
         end
      end else if (upd_valid) begin
         if (up_hit) begin
`ifdef FETCH_BHT_EN
            mem[up_idx].ctr    <= ctr_next(mem[up_idx].ctr, upd_taken);
            mem[up_idx].target <= upd_target;
`else
            if (upd_taken) mem[up_idx].target <= upd_target;
            else           mem[up_idx].valid  <= 1'b0;
`endif
         end else if (upd_taken) begin
            mem[up_idx].valid  <= 1'b1;
            mem[up_idx].tag    <= up_tag;
            mem[up_idx].target <= upd_target;
`ifdef FETCH_BHT_EN
            mem[up_idx].ctr    <= CTR_WT;
`endif
         end
      end
   end
endmodule

// File: rtl/fetch_pred.sv
// Fetch pc register and next-pc selection around a BTB predictor.
// Optional macro FETCH_BHT_EN enables 2-bit direction counters in the BTB.
module fetch_pred
   import fetch_pkg::*;
#(
   parameter int          BTB_ENTRIES = 16,
   parameter logic [31:0] RESET_PC    = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] pc,
   output logic [31:0] nextpc,
   output logic        pred_taken,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic [31:0] upd_target,
   input  logic        upd_taken
);
   pc_t btb_target;
   pc_t pred_pc;

   fetch_btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
      .clk        (clk),
      .reset      (reset),
      .rd_pc      (pc),
      .rd_taken   (pred_taken),
      .rd_target  (btb_target),
      .upd_valid  (upd_valid),
      .upd_pc     (upd_pc),
      .upd_target (upd_target),
      .upd_taken  (upd_taken)
   );

   assign pred_pc = pred_taken ? btb_target : pc + 32'd4;
   assign nextpc  = redirect ? redirect_pc : pred_pc;

   // A redirect must land even while the front end is stalled
   always_ff @(posedge clk) begin
      if (reset)                  pc <= RESET_PC;
      else if (redirect || !stall) pc <= nextpc;
   end
endmodule

// File: tb/tb_fetch_pred.sv
// Bench for fetch_pred: directed pins plus random traffic against a table model.
// Follows FETCH_BHT_EN the same way the design does.
module tb_fetch_pred;
   localparam int N = 16;
   localparam int IDX = 4;

   logic        clk = 1'b0;
   logic        reset, stall, redirect, upd_valid, upd_taken;
   logic [31:0] redirect_pc, upd_pc, upd_target;
   logic [31:0] pc, nextpc;
   logic        pred_taken;

   fetch_pred #(.BTB_ENTRIES(N), .RESET_PC(32'h0)) dut (
      .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .pc(pc), .nextpc(nextpc), .pred_taken(pred_taken),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken)
   );

   // clock / reset block
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   // behavioural model: a table of entries, pc and a liveness flag
   bit          live = 0;
   bit          m_valid [N];
   logic [31:0] m_tag [N];
   logic [31:0] m_tgt [N];
   int          m_ctr [N];
   logic [31:0] m_pc;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
      end
   endtask

   function automatic bit m_hit(input logic [31:0] a);
      int i = int'((a / 4) % N);
      return m_valid[i] && (m_tag[i] == a / (4 * N));
   endfunction

   function automatic bit m_taken(input logic [31:0] a);
      int i = int'((a / 4) % N);
`ifdef FETCH_BHT_EN
      return m_hit(a) && (m_ctr[i] >= 2);
`else
      return m_hit(a);
`endif
   endfunction

   function automatic logic [31:0] m_next();
      if (redirect) return redirect_pc;
      if (m_taken(m_pc)) return m_tgt[int'((m_pc / 4) % N)];
      return m_pc + 32'd4;
   endfunction

   // driver: apply inputs away from the edge, then compare against the model
   task automatic drive(input bit rst, input bit s, input bit r, input logic [31:0] rpc,
                        input bit uv, input logic [31:0] upc, input logic [31:0] utg, input bit ut);
      @(negedge clk);
      reset = rst; stall = s; redirect = r; redirect_pc = rpc;
      upd_valid = uv; upd_pc = upc; upd_target = utg; upd_taken = ut;
      #1;
      if (live) begin
         if (exp_q.size() > 0) chk("pc", pc, exp_q.pop_front());
         chk("nextpc", nextpc, m_next());
         chk("pred_taken", {31'b0, pred_taken}, {31'b0, m_taken(m_pc)});
      end
   endtask

   task automatic tick();
      logic [31:0] np;
      int i;
      @(posedge clk);
      np = m_next();
      if (reset) begin
         live = 1;
         m_pc = 32'h0;
         for (int k = 0; k < N; k++) begin m_valid[k] = 0; m_ctr[k] = 1; end
      end else begin
         if (redirect || !stall) m_pc = np;
         if (upd_valid) begin
            i = int'((upd_pc / 4) % N);
            if (m_hit(upd_pc)) begin
`ifdef FETCH_BHT_EN
               m_ctr[i] = upd_taken ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                                    : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
               m_tgt[i] = upd_target;
`else
               if (upd_taken) m_tgt[i] = upd_target;
               else m_valid[i] = 0;
`endif
            end else if (upd_taken) begin
               m_valid[i] = 1; m_tag[i] = upd_pc / (4 * N); m_tgt[i] = upd_target; m_ctr[i] = 2;
            end
         end
      end
      exp_q.push_back(m_pc);
   endtask

   task automatic idle();
      drive(0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
   endtask

   function automatic logic [31:0] rand_addr();
      if ($urandom_range(0, 31) == 0) return 32'hFFFF_FFFC;
      return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
             | 32'($urandom_range(0, 3));
   endfunction

   initial begin
      drive(1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0); tick();
      drive(1, 0, 0, 32'h0, 1, 32'h10, 32'h80, 1); tick();   // reset beats update

      // free run with an allocation at 0x10 issued in the first cycle
      drive(0, 0, 0, 32'h0, 1, 32'h10, 32'h40, 1);
      chk("run_pc0", pc, 32'h0); chk("run_pt0", {31'b0, pred_taken}, 32'h0); tick();
      idle(); chk("run_pc4", pc, 32'h4); chk("run_pt4", {31'b0, pred_taken}, 32'h0); tick();
      idle(); chk("run_pc8", pc, 32'h8); chk("run_pt8", {31'b0, pred_taken}, 32'h0); tick();
      idle(); chk("run_pc12", pc, 32'hC); chk("run_pt12", {31'b0, pred_taken}, 32'h0); tick();
      idle(); chk("hit_pc", pc, 32'h10); chk("hit_pt", {31'b0, pred_taken}, 32'h1);
      chk("hit_next", nextpc, 32'h40); tick();
      idle(); chk("hit_jump", pc, 32'h40); tick();

      // alias at index 4 with a different tag
      drive(0, 0, 1, 32'h50, 0, 32'h0, 32'h0, 0); tick();
      idle(); chk("alias_pt", {31'b0, pred_taken}, 32'h0); chk("alias_next", nextpc, 32'h54); tick();

      // redirect beats stall; stall alone holds
      drive(0, 1, 1, 32'h200, 0, 32'h0, 32'h0, 0); tick();
      drive(0, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0); chk("stall_redir", pc, 32'h200); tick();
      idle(); chk("stall_hold", pc, 32'h200); tick();

      // wrap-around of pc+4
      drive(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 0); tick();
      idle(); chk("wrap_next", nextpc, 32'h0); tick();

`ifdef FETCH_BHT_EN
      drive(0, 0, 0, 32'h0, 1, 32'h10, 32'h40, 0); tick();
      drive(0, 0, 0, 32'h0, 1, 32'h10, 32'h40, 0); tick();
      drive(0, 0, 1, 32'h10, 0, 32'h0, 32'h0, 0); tick();
      drive(0, 0, 0, 32'h0, 1, 32'h10, 32'h40, 0);
      chk("ctr0_pc", pc, 32'h10); chk("ctr0_next", nextpc, 32'h14);
      chk("ctr0_pt", {31'b0, pred_taken}, 32'h0); tick();
      // a still-valid entry moves 0->1 on taken, so prediction stays not-taken
      drive(0, 0, 0, 32'h0, 1, 32'h10, 32'h40, 1); tick();
      drive(0, 0, 1, 32'h10, 0, 32'h0, 32'h0, 0); tick();
      idle(); chk("ctr0_valid", {31'b0, pred_taken}, 32'h0); tick();
`else
      drive(0, 0, 0, 32'h0, 1, 32'h10, 32'h40, 0); tick();
      drive(0, 0, 1, 32'h10, 0, 32'h0, 32'h0, 0); tick();
      idle(); chk("nt_clear_pt", {31'b0, pred_taken}, 32'h0); chk("nt_clear_next", nextpc, 32'h14); tick();
`endif

      // reset mid-run clears the table
      drive(0, 0, 0, 32'h0, 1, 32'h10, 32'h40, 1); tick();
      drive(1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0); tick();
      idle(); chk("rst_pc", pc, 32'h0); tick();
      drive(0, 0, 1, 32'h10, 0, 32'h0, 32'h0, 0); tick();
      idle(); chk("rst_miss", {31'b0, pred_taken}, 32'h0); chk("rst_next", nextpc, 32'h14); tick();

      // random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
               rand_addr(), $urandom_range(0, 1) == 1, rand_addr(), rand_addr(),
               $urandom_range(0, 2) != 0);
         tick();
      end
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
